// File: rtl/tetris_pkg.sv
// Shared Tetris game-flow types, widths and the gravity period lookup.
package tetris_pkg;

    // Width of the board's cleared-row count (1..4 rows).
    localparam int unsigned LINES_W = 3;

    // Game-flow phases; ST_PAUSED is only reachable when GAME_PAUSE_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } game_state_t;

    // Gravity period in frame ticks at a given level, floored at floor_p.
    // Signed int arithmetic keeps high levels from wrapping below the floor.
    function automatic int grav_period(input int lvl, input int base,
                                       input int step, input int floor_p);
        int p;
        p = base - (lvl * step);
        if (p < floor_p) begin
            p = floor_p;
        end
        return p;
    endfunction

endpackage

// File: rtl/game_sequencer_gravity_timer.sv
// Gravity timer: counts frame ticks in PLAY and pulses once per level-dependent period.
module gravity_timer #(
    parameter int unsigned LW        = 3,
    parameter int unsigned GRAV_BASE = 48,
    parameter int unsigned GRAV_STEP = 5,
    parameter int unsigned GRAV_MIN  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_run,
    input  logic          i_frame_tick,
    input  logic [LW-1:0] i_level,
    output logic          o_tick
);
    import tetris_pkg::*;

    localparam int unsigned CW = $clog2(GRAV_BASE + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_period;
    logic          r_tick;

    // Period lookup for the current level.
    always_comb begin
        w_period = CW'(grav_period(int'(i_level), int'(GRAV_BASE),
                                   int'(GRAV_STEP), int'(GRAV_MIN)));
    end

    // Counter: cleared on spawn, clamped after a level step shortens the period,
    // otherwise advanced by frame ticks only while the game keeps playing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_clear || (r_cnt >= w_period)) begin
                r_cnt <= '0;
            end else if (i_run && i_frame_tick) begin
                if (r_cnt == (w_period - CW'(1))) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/game_sequencer.sv
// Tetris game-flow sequencer: phase FSM, line/level accounting and gravity tick.
// Optional pause support is built when GAME_PAUSE_EN is defined.
module game_sequencer
    import tetris_pkg::*;
#(
    parameter int unsigned SPAWN_CYCLES    = 2,
    parameter int unsigned CLEAR_CYCLES    = 4,
    parameter int unsigned LEVELS          = 8,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned GRAV_BASE       = 48,
    parameter int unsigned GRAV_STEP       = 5,
    parameter int unsigned GRAV_MIN        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_game,
    input  logic                       frame_tick,
    input  logic                       fell,
    input  logic                       line_break,
    input  logic [LINES_W-1:0]         lines_cleared,
    input  logic                       game_over,
    input  logic                       pause,
    output logic                       spawn_block,
    output logic                       line_break_mode,
    output logic                       game_over_mode,
    output logic                       playing,
    output logic                       gravity_tick,
    output logic [$clog2(LEVELS)-1:0]  level,
    output logic [15:0]                lines_total
);

    localparam int unsigned LW     = $clog2(LEVELS);
    localparam int unsigned PH_MAX = (SPAWN_CYCLES > CLEAR_CYCLES) ? SPAWN_CYCLES : CLEAR_CYCLES;
    localparam int unsigned PW     = $clog2(PH_MAX + 1);
    localparam int unsigned LL_W   = $clog2(LINES_PER_LEVEL + 8);

    game_state_t     r_state;
    game_state_t     w_next;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_next;
    logic [LW-1:0]   r_level;
    logic [15:0]     r_lines_total;
    logic [LL_W-1:0] r_lvl_lines;
    logic [16:0]     w_total_sum;
    logic [LL_W-1:0] w_lvl_sum;
    logic            r_spawn;
    logic            r_clear_mode;
    logic            r_over_mode;
    logic            r_playing;
    logic            w_grav_clear;
    logic            w_grav_run;
    logic            w_pause_rise;

`ifdef GAME_PAUSE_EN
    logic r_pause_d;

    // Pause request edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_d <= 1'b0;
        end else begin
            r_pause_d <= pause;
        end
    end

    assign w_pause_rise = pause & ~r_pause_d;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_pause_rise   = 1'b0;
`endif

    // Next-state and phase-counter logic; board inputs only matter in PLAY.
    always_comb begin
        w_next       = r_state;
        w_phase_next = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_game) w_next = ST_SPAWN;
            end
            ST_SPAWN: begin
                if (r_phase == PW'(SPAWN_CYCLES - 1)) w_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (game_over)         w_next = ST_OVER;
                else if (fell)         w_next = ST_SPAWN;
                else if (line_break)   w_next = ST_CLEAR;
                else if (w_pause_rise) w_next = ST_PAUSED;
            end
            ST_CLEAR: begin
                if (r_phase == PW'(CLEAR_CYCLES - 1)) w_next = ST_PLAY;
            end
            ST_OVER: begin
                if (start_game) w_next = ST_IDLE;
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (w_pause_rise) w_next = ST_PLAY;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
        if ((w_next == r_state) && ((r_state == ST_SPAWN) || (r_state == ST_CLEAR))) begin
            w_phase_next = r_phase + PW'(1);
        end
    end

    // Line accounting sums; the level counter carries the remainder between steps.
    assign w_total_sum = {1'b0, r_lines_total} + 17'(lines_cleared);
    assign w_lvl_sum   = r_lvl_lines + LL_W'(lines_cleared);

    // State, registered Moore strobes, and line/level accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_level       <= '0;
            r_lines_total <= '0;
            r_lvl_lines   <= '0;
            r_spawn       <= 1'b0;
            r_clear_mode  <= 1'b0;
            r_over_mode   <= 1'b0;
            r_playing     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_phase      <= w_phase_next;
            r_spawn      <= (w_next == ST_SPAWN);
            r_clear_mode <= (w_next == ST_CLEAR);
            r_over_mode  <= (w_next == ST_OVER);
            r_playing    <= (w_next == ST_PLAY);
            if ((r_state == ST_IDLE) && (w_next == ST_SPAWN)) begin
                r_level       <= '0;
                r_lines_total <= '0;
                r_lvl_lines   <= '0;
            end else if ((r_state == ST_PLAY) && (w_next == ST_CLEAR)) begin
                r_lines_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                if (w_lvl_sum >= LL_W'(LINES_PER_LEVEL)) begin
                    r_lvl_lines <= w_lvl_sum - LL_W'(LINES_PER_LEVEL);
                    if (r_level != LW'(LEVELS - 1)) begin
                        r_level <= r_level + LW'(1);
                    end
                end else begin
                    r_lvl_lines <= w_lvl_sum;
                end
            end
        end
    end

    // Gravity counter restarts on every spawn and only runs while staying in PLAY.
    assign w_grav_clear = (w_next == ST_SPAWN) && (r_state != ST_SPAWN);
    assign w_grav_run   = (r_state == ST_PLAY) && (w_next == ST_PLAY);

    gravity_timer #(
        .LW        (LW),
        .GRAV_BASE (GRAV_BASE),
        .GRAV_STEP (GRAV_STEP),
        .GRAV_MIN  (GRAV_MIN)
    ) u_gravity_timer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_grav_clear),
        .i_run        (w_grav_run),
        .i_frame_tick (frame_tick),
        .i_level      (r_level),
        .o_tick       (gravity_tick)
    );

    assign spawn_block     = r_spawn;
    assign line_break_mode = r_clear_mode;
    assign game_over_mode  = r_over_mode;
    assign playing         = r_playing;
    assign level           = r_level;
    assign lines_total     = r_lines_total;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level Tetris game-flow sequencer: a parametrised successor to the single-difficulty game control FSM. It sequences idle/spawn/play/line-clear/game-over phases with configurable phase durations. It also generates the gravity tick that drives piece descent, tracks cleared lines, and advances the difficulty level, which shortens the gravity period. It sits between the board logic (which reports `fell`, `line_break`, `lines_cleared`, `game_over`) and the piece/board datapaths, which consume the mode strobes.

## Interface
- `SPAWN_CYCLES`, 2: cycles `spawn_block` is held high per spawn (≥1).
- `CLEAR_CYCLES`, 4: cycles `line_break_mode` is held high per clear (≥1).
- `LEVELS`, 8: number of difficulty levels (≥2).
- `LINES_PER_LEVEL`, 10: lines needed to advance one level (≥1).
- `GRAV_BASE`, 48: gravity period in `frame_tick`s at level 0.
- `GRAV_STEP`, 5: period reduction per level.
- `GRAV_MIN`, 4: period floor (≥1, ≤ GRAV_BASE).
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start_game` in 1: start request (level-sensitive).
- `frame_tick` in 1: one-cycle frame strobe; gravity time base.
- `fell` in 1: active piece locked.
- `line_break` in 1: one or more full rows detected.
- `lines_cleared` in 3: row count, 1–4; valid when `line_break` is high.
- `game_over` in 1: spawn collision or top-out.
- `pause` in 1: pause toggle request (see Configuration).
- `spawn_block` out 1: spawn strobe.
- `line_break_mode` out 1: board performs row removal.
- `game_over_mode` out 1: game-over display.
- `playing` out 1: state is PLAY.
- `gravity_tick` out 1: one-cycle pulse; move the piece down one row.
- `level` out clog2(LEVELS): current level.
- `lines_total` out 16: lines cleared this game, saturating at 0xFFFF.

## Operation
- States: IDLE, SPAWN, PLAY, CLEAR, OVER, PAUSED (PAUSED exists only with the macro).
- Reset values:
  - state IDLE.
  - All 1-bit outputs 0.
  - `level` = 0, `lines_total` = 0.
  - Gravity counter and phase counter = 0.
- IDLE: on `start_game`, go to SPAWN and clear `level`, `lines_total`, the level line counter, and the gravity counter.
- SPAWN: `spawn_block` = 1 for exactly SPAWN_CYCLES cycles, then go to PLAY.
- PLAY: `playing` = 1. Inputs are sampled each cycle with priority `game_over` > `fell` > `line_break`:
  - `game_over` → OVER.
  - `fell` → SPAWN.
  - `line_break` → CLEAR; `lines_cleared` is latched on this cycle.
- CLEAR: `line_break_mode` = 1 for exactly CLEAR_CYCLES cycles, then go to PLAY.
  - On CLEAR entry, `lines_total` += latched count (saturating) and the level line counter += count.
  - If the level line counter reaches ≥ LINES_PER_LEVEL: subtract LINES_PER_LEVEL and increment `level`, saturating at LEVELS−1. Only one level step is taken per clear.
- OVER: `game_over_mode` = 1. `level` and `lines_total` are held. On `start_game`, go to IDLE. Returning to IDLE takes one cycle, so holding `start_game` restarts the game on the following cycle.
- Gravity:
  - period(L) = max(GRAV_BASE − L·GRAV_STEP, GRAV_MIN). Compute in signed or widened arithmetic so there is no underflow.
  - The counter advances only on `frame_tick` while in PLAY.
  - When the counter = period−1 and `frame_tick` is high: `gravity_tick` pulses and the counter returns to 0.
  - The counter resets to 0 on SPAWN entry. It holds in CLEAR and PAUSED.
  - When the level increases, the counter is clamped to 0 if it is ≥ the new period.
- `reset` mid-game (any state): return to IDLE next edge with all reset values; any latched count is discarded.
- `fell`, `line_break`, and `game_over` are ignored outside PLAY.

## Timing
- All outputs are registered (Moore). Each strobe asserts the cycle after the state is entered.
- `start_game` in IDLE at edge N: `spawn_block` is high for cycles N+1 … N+SPAWN_CYCLES, and `playing` is high from N+SPAWN_CYCLES+1.
- `fell` in PLAY at edge N: `playing` drops at N+1 and `spawn_block` rises at N+1.
- `line_break` at edge N: `line_break_mode` is high N+1 … N+CLEAR_CYCLES. `lines_total`/`level` update at N+1.
- `gravity_tick` is a single-cycle pulse, at most one per `frame_tick`, and is never asserted outside PLAY.

## Configuration
- `GAME_PAUSE_EN` defined:
  - A rising edge of `pause` (registered edge detect) in PLAY → PAUSED.
  - In PAUSED, all strobes are 0 and `playing` = 0. Only a `pause` rising edge → PLAY, resuming with the gravity counter preserved.
  - `reset` still overrides.
- Undefined: `pause` is ignored, the PAUSED state and edge detector are not built, and behaviour is otherwise identical.

## Structure
- Shared package `tetris_pkg` holds:
  - the state enum `game_state_t`;
  - the `lines_cleared` width constant;
  - the `grav_period(level)` function.
- Natural sub-module: `gravity_timer` (frame-tick counter, period lookup, clamp on level change). The FSM, phase counter, and line/level accounting stay in `game_sequencer`.

## Test plan
- Reset, then `start_game` = 1 for one cycle (defaults) → `spawn_block` high exactly 2 cycles, then `playing` = 1, `level` = 0.
- In PLAY, assert `game_over`, `fell`, and `line_break` in the same cycle → OVER, `game_over_mode` = 1, `lines_total` unchanged.
- Three clears of 4 lines each → `lines_total` = 12, `level` = 1 after the third; `line_break_mode` high 4 cycles each time.
- Level 0, continuous `frame_tick` → `gravity_tick` every 48 cycles. Force level 9 (LEVELS = 16) → period 4 (floor).
- `reset` asserted during CLEAR → IDLE next cycle, all outputs 0, `level` = 0, `lines_total` = 0.
- With `GAME_PAUSE_EN`: `pause` pulse in PLAY → no `gravity_tick` for 200 frames; second pulse resumes with the counter preserved.
